// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states and
// the alignment rule applied when a request is accepted.
package lsu_pkg;

  localparam int DM_AW_DEFAULT = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } lsu_state_t;

  // Size 2'b11 is illegal and therefore always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// Little-endian lane steering: merges store data into an old word and
// extracts/extends load data from a memory word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_sh  = {lo, 3'b000};
  assign half_sh  = {lo[1], 4'b0000};
  assign byte_val = old_word[byte_sh +: 8];
  assign half_val = old_word[half_sh +: 16];

  always_comb begin
    merged    = old_word;
    load_word = '0;
    case (size)
      SZ_BYTE: begin
        merged[byte_sh +: 8] = wdata[7:0];
        load_word = {{24{sign_ext & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        merged[half_sh +: 16] = wdata[15:0];
        load_word = {{16{sign_ext & half_val[15]}}, half_val};
      end
      SZ_WORD: begin
        merged    = wdata;
        load_word = old_word;
      end
      default: begin
        merged    = old_word;
        load_word = '0;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and a word-addressed data memory;
// sub-word stores are done as read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DM_AW = DM_AW_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on a rising edge where req=1 and ready=1;
  // done pulses for one cycle with rdata/misalign valid; req while busy is dropped.

  lsu_state_t  state, state_nx;
  logic        op_we;
  logic [1:0]  op_size;
  logic        op_sext;
  logic [1:0]  op_lo;
  logic [31:0] op_wdata;
  logic [31:0] merged;
  logic [31:0] load_word;
  logic        accept_mis;
  logic        unused_addr;

  assign unused_addr = &{1'b0, addr[31:DM_AW+2]};
  assign accept_mis  = is_misaligned(size, addr[1:0]);
  assign state_dbg   = state;

  lsu_lane_mux u_lane_mux (
    .old_word  (mem_rdata),
    .wdata     (op_wdata),
    .lo        (op_lo),
    .size      (op_size),
    .sign_ext  (op_sext),
    .merged    (merged),
    .load_word (load_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (accept_mis)                   state_nx = DONE;
          else if (we && size == SZ_WORD)   state_nx = WRITE;
          else                              state_nx = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        state_nx = op_we ? WRITE : DONE;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_nx  = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_we     <= 1'b0;
      op_size   <= SZ_BYTE;
      op_sext   <= 1'b0;
      op_lo     <= 2'b00;
      op_wdata  <= '0;
      rdata     <= '0;
      misalign  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_we    <= we;
          op_size  <= size;
          op_sext  <= sign_ext;
          op_lo    <= addr[1:0];
          op_wdata <= wdata;
          mem_addr <= {{(32-DM_AW){1'b0}}, addr[DM_AW+1:2]};
          if (accept_mis) begin
            misalign <= 1'b1;
            rdata    <= '0;
          end else if (we && size == SZ_WORD) begin
            mem_wdata <= wdata;
          end
        end
        // Old word is sampled combinationally from memory in the READ cycle.
        READ: begin
          if (op_we) begin
            mem_wdata <= merged;
          end else begin
            rdata    <= load_word;
            misalign <= 1'b0;
          end
        end
        WRITE: begin
          rdata    <= '0;
          misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench: a byte-array reference model predicts load data, write
// words, strobe counts and latency for directed and random requests.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, misalign, mem_write, mem_read;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem [1024] = '{default: 32'h0};
  logic [7:0]  ref_mem [4096] = '{default: 8'h0};
  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  lsu_mem_master #(.DM_AW(10)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
    .done(done), .rdata(rdata), .misalign(misalign), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[9:0]];

  task automatic preload(input logic [9:0] idx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    for (int i = 0; i < 4; i++) ref_mem[{idx, 2'b00} + 12'(i)] = d[8*i +: 8];
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic hold, input string tag);
    logic        mis, seen, got_mis;
    logic [31:0] exp_rd, exp_wd, exp_ma, got_wa, got_wd, got_rd;
    logic [11:0] start, wbase;
    int          exp_lat, exp_rds, exp_wrs, lat, rds, wrs, v, nbytes;

    mis     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_ma  = {22'd0, a[11:2]};
    wbase   = {a[11:2], 2'b00};
    exp_rd  = '0; exp_wd = '0; exp_rds = 0; exp_wrs = 0;
    nbytes  = 1 << sz;
    start   = (sz == 2'b00) ? a[11:0] : (sz == 2'b01) ? {a[11:1], 1'b0} : wbase;
    if (mis) begin
      exp_lat = 1;
    end else if (!w) begin
      exp_lat = 2; exp_rds = 1;
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v + int'(ref_mem[start + 12'(i)]) * (1 << (8*i));
      if (sz != 2'b10 && sx && v >= (1 << (8*nbytes - 1))) v = v - (1 << (8*nbytes));
      exp_rd = (sz == 2'b10) ? {ref_mem[wbase+3], ref_mem[wbase+2], ref_mem[wbase+1], ref_mem[wbase]}
                             : 32'(v);
    end else begin
      exp_lat = (sz == 2'b10) ? 2 : 3;
      exp_rds = (sz == 2'b10) ? 0 : 1;
      exp_wrs = 1;
      for (int i = 0; i < nbytes; i++) ref_mem[start + 12'(i)] = wd[8*i +: 8];
      exp_wd = {ref_mem[wbase+3], ref_mem[wbase+2], ref_mem[wbase+1], ref_mem[wbase]};
    end
    exp_q.push_back(exp_rd);

    @(negedge clk);
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_idle: got %b want 1", tag, ready);
    end
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    if (!hold) begin
      req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
      addr = $urandom; wdata = $urandom;
    end

    lat = 0; rds = 0; wrs = 0; seen = 1'b0; got_wa = '0; got_wd = '0; got_rd = '0; got_mis = 1'b0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (mem_read) rds++;
      if (mem_write) begin
        wrs++; got_wa = mem_addr; got_wd = mem_wdata;
      end
      vectors++;
      if (mem_read && mem_write) begin
        miscompares++; $display("FAIL %s strobe_overlap: got read=1 write=1 want exclusive", tag);
      end
      vectors++;
      if (mem_addr !== exp_ma) begin
        miscompares++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, exp_ma);
      end
      if (done) begin
        seen = 1'b1; got_rd = rdata; got_mis = misalign;
        if (hold) req = 1'b0;
      end else begin
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++; $display("FAIL %s ready_busy: got %b want 0", tag, ready);
        end
      end
    end
    req = 1'b0;

    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL %s done_timeout: got no done want done within 8 cycles", tag);
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    exp_rd = exp_q.pop_front();
    vectors++;
    if (got_rd !== exp_rd) begin
      miscompares++; $display("FAIL %s rdata: got %h want %h", tag, got_rd, exp_rd);
    end
    vectors++;
    if (got_mis !== mis) begin
      miscompares++; $display("FAIL %s misalign: got %b want %b", tag, got_mis, mis);
    end
    vectors++;
    if (rds !== exp_rds || wrs !== exp_wrs) begin
      miscompares++;
      $display("FAIL %s strobe_count: got reads=%0d writes=%0d want reads=%0d writes=%0d",
               tag, rds, wrs, exp_rds, exp_wrs);
    end
    if (exp_wrs > 0) begin
      vectors++;
      if (got_wa !== exp_ma || got_wd !== exp_wd) begin
        miscompares++;
        $display("FAIL %s write_word: got addr=%h data=%h want addr=%h data=%h",
                 tag, got_wa, got_wd, exp_ma, exp_wd);
      end
    end

    @(negedge clk);
    vectors++;
    if ({ready, done, mem_read, mem_write} !== 4'b1000) begin
      miscompares++;
      $display("FAIL %s after_done: got ready/done/rd/wr=%b want 1000", tag,
               {ready, done, mem_read, mem_write});
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({ready, done, misalign, mem_read, mem_write, rdata, mem_addr, mem_wdata} !==
        {1'b1, 4'b0000, 96'h0}) begin
      miscompares++;
      $display("FAIL %s reset_values: got ready=%b done=%b mis=%b rd=%b wr=%b rdata=%h maddr=%h mwdata=%h want ready=1 rest 0",
               tag, ready, done, misalign, mem_read, mem_write, rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset");
  endtask

  task automatic test_sw_lw();
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, "sw");
    do_req(1'b0, SZ_WORD, 1'b1, 32'h0000_0008, 32'h0, 1'b0, "lw");
  endtask

  task automatic test_sb_merge();
    preload(10'd2, 32'h1122_3344);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h0000_0009, 32'h0000_00AA, 1'b0, "sb_merge");
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0008, 32'h0, 1'b0, "sb_readback");
  endtask

  task automatic test_extension();
    preload(10'd2, 32'h80FF_7F01);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h0000_000A, 32'h0, 1'b0, "lb_a");
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h0000_000B, 32'h0, 1'b0, "lbu_b");
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0000_000A, 32'h0, 1'b0, "lh_a");
    do_req(1'b0, SZ_HALF, 1'b1, 32'h0000_0008, 32'h0, 1'b0, "lh_8");
    do_req(1'b0, SZ_HALF, 1'b0, 32'h0000_000A, 32'h0, 1'b0, "lhu_a");
  endtask

  task automatic test_misalign();
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0006, 32'h0, 1'b0, "lw_mis");
    do_req(1'b1, SZ_HALF, 1'b0, 32'h0000_0003, 32'h1234_5678, 1'b0, "sh_mis");
    do_req(1'b0, 2'b11,   1'b1, 32'h0000_0004, 32'h0, 1'b0, "sz11_ld");
    do_req(1'b1, 2'b11,   1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 1'b0, "sz11_st");
  endtask

  task automatic test_busy_wrap();
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h0000_000E, 32'h0000_0077, 1'b1, "sb_held");
    do_req(1'b1, SZ_WORD, 1'b0, 32'h0000_1004, 32'hCAFE_F00D, 1'b0, "sw_wrap");
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_0004, 32'h0, 1'b0, "lw_wrap");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      a = $urandom & 32'hFFFF_F03F;
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_op();
    int wr_seen;
    preload(10'd3, 32'h5566_7788);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h0000_000D; wdata = 32'h0000_00EE;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++; $display("FAIL mid_reset read_cycle: got mem_read=%b want 1", mem_read);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("mid_reset");
    wr_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_write) wr_seen++;
      @(negedge clk);
    end
    vectors++;
    if (wr_seen !== 0) begin
      miscompares++; $display("FAIL mid_reset no_write: got %0d writes want 0", wr_seen);
    end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0000_000C, 32'h0, 1'b0, "mid_reset_readback");
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb_merge();
    test_extension();
    test_misalign();
    test_busy_wrap();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator sitting between the MEM pipeline stage and the word-addressed data memory.
- Accepts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests from the pipeline and converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores and extracts/extends sub-word load data.
- Drives the memory's addr/data_in/MemWrite/MemRead inputs and samples its combinational data_out.

Parameters:
- DM_AW, 10, word-index width of the data memory (1024 words); the word index wraps modulo 2^DM_AW.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request strobe, sampled only when ready=1
- we  in  1  1=store, 0=load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned (low byte/half used for sb/sh)
- ready  out  1  block idle, can accept req
- done  out  1  one-cycle pulse, request complete
- rdata  out  32  load result, valid while done=1
- misalign  out  1  valid with done: request rejected, no memory access
- mem_addr  out  32  word index to memory
- mem_wdata  out  32  word to memory
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state=IDLE. ready=1; done, misalign, mem_write, mem_read=0; rdata, mem_addr, mem_wdata=0. Reset asserted in any state aborts the operation; no mem_write is issued in the following cycle.
- Accept: in IDLE with req=1, latch we/size/sign_ext/addr/wdata. ready=1 only in IDLE; req in any other state is ignored.
- Error check at accept:
  - size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> go to DONE with misalign=1.
  - No mem_read or mem_write is asserted; rdata=0.
- Word index: mem_addr = zero-extended addr[DM_AW+1:2]. It is held constant from accept through DONE; otherwise it holds its last value.
- States: IDLE, READ, WRITE, DONE.
  - Load: IDLE -> READ (mem_read=1; register the lane-extracted mem_rdata at end of cycle) -> DONE.
  - sw: IDLE -> WRITE (mem_write=1, mem_wdata=wdata) -> DONE.
  - sb/sh: IDLE -> READ (mem_read=1, capture old word) -> WRITE (mem_write=1, mem_wdata=merged word) -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency from accepting edge to done high: load 2 cycles, sw 2, sb/sh 3, misaligned 1. Back-to-back throughput: one request per (latency+1) cycles.
- Lanes are little-endian:
  - byte lane = addr[1:0] (bits [8k+7:8k]);
  - half lane = addr[1] (bits [16h+15:16h]).
  - Merge replaces only the addressed lane; other bytes keep their old value.
- Extension: lb/lh sign-extend from the lane MSB when sign_ext=1, otherwise zero-extend. For lw, sign_ext is ignored.
- Strobes: mem_read and mem_write are never both 1. Each is high exactly one cycle per request. mem_wdata is meaningful only while mem_write=1.
- rdata and misalign are updated when DONE is entered and hold until the next DONE. Stores set rdata=0.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state enum IDLE/READ/WRITE/DONE;
  - DM_AW default constant.
- Sub-module lsu_lane_mux: combinational only.
  - Inputs: old word, wdata, addr[1:0], size, sign_ext.
  - Outputs: merged store word and extended load word.
  - Instantiated once; the FSM stays in lsu_mem_master.

Test Plan:
- Reset mid-op: sb accepted, reset asserted in the READ cycle -> no mem_write on any following cycle; outputs return to reset values; ready=1.
- sw then lw: sw addr=0x0000_0008, wdata=0xDEADBEEF -> mem_write high once with mem_addr=2, mem_wdata=0xDEADBEEF, done 2 cycles after accept. lw addr=0x8 -> rdata=0xDEADBEEF, done 2 cycles after accept.
- sb merge: word 2 holds 0x11223344; sb addr=0x9, wdata=0x000000AA -> one mem_read, then mem_write 0x1122AA44, done 3 cycles after accept.
- lb/lbu/lh extension: word 2=0x80FF7F01.
  - lb addr=0xA, sign_ext=1 -> 0xFFFFFFFF.
  - lbu addr=0xB -> 0x00000080.
  - lh addr=0xA, sign_ext=1 -> 0xFFFF80FF.
  - lh addr=0x8, sign_ext=1 -> 0x00007F01.
- Misaligned requests: lw addr=0x6, sh addr=0x3, size=11 -> done 1 cycle after accept with misalign=1, rdata=0, mem_read and mem_write never asserted.
- Busy/wrap: req held high during an sb -> only one request accepted until ready returns. sw addr=0x0000_1004 with DM_AW=10 -> mem_addr=1.
